inst_prefetch_queue: RTL

//  Parametrised instruction queue between fetch and decode. Accepts up to FETCH_W
//  32-bit instructions per cycle and pre-decodes each at enqueue (jal/jalr/bxx, bp imm, rs1idx).

---
 rtl/inst_prefetch_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode: multi-lane enqueue with
// predecode at write time, single-entry dequeue via valid/ready, flush on redirect.
`timescale 1ns/1ps

module inst_prefetch_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic                           i_enq_vld,
    input  logic [$clog2(FETCH_W+1)-1:0]   i_enq_num,
    input  logic [32*FETCH_W-1:0]          i_enq_inst,
    input  logic [XLEN-1:0]                i_enq_pc,
    input  logic [FETCH_W-1:0]             i_enq_bflag,
    output logic                           o_enq_rdy,
    output logic                           o_deq_vld,
    input  logic                           i_deq_rdy,
    output logic [31:0]                    o_deq_inst,
    output logic [XLEN-1:0]                o_deq_pc,
    output logic                           o_deq_bflag,
    output logic                           o_deq_jal,
    output logic                           o_deq_jalr,
    output logic                           o_deq_bxx,
    output logic [4:0]                     o_deq_rs1idx,
    output logic [XLEN-1:0]                o_deq_bp_imm,
    output logic [$clog2(DEPTH):0]         o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned NW = $clog2(FETCH_W + 1);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic            bflag;
        logic            jal;
        logic            jalr;
        logic            bxx;
        logic [4:0]      rs1idx;
        logic [XLEN-1:0] imm;
    } entry_t;

    // Classify an instruction and extract its branch-target immediate.
    function automatic entry_t predecode(input logic [31:0] inst,
                                         input logic [XLEN-1:0] pc,
                                         input logic bflag);
        entry_t e;
        logic   rv32;
        rv32     = (inst[1:0] == 2'b11);
        e.inst   = inst;
        e.pc     = pc;
        e.bflag  = bflag;
        e.jal    = rv32 && (inst[6:2] == 5'b11011);
        e.jalr   = rv32 && (inst[6:2] == 5'b11001);
        e.bxx    = rv32 && (inst[6:2] == 5'b11000);
        e.rs1idx = inst[19:15];
        e.imm    = '0;
        if (e.jal)
            e.imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        else if (e.jalr)
            e.imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
        else if (e.bxx)
            e.imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        return e;
    endfunction

    entry_t          mem [DEPTH];
    entry_t          lane [FETCH_W];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic            num_ok;
    logic            enq_fire;
    logic            deq_fire;

    assign count     = wr_ptr - rd_ptr;
    assign o_count   = count;
    assign o_deq_vld = (wr_ptr != rd_ptr);
    assign o_enq_rdy = (DEPTH - 32'(count)) >= FETCH_W;

    assign num_ok   = (i_enq_num != '0) && (32'(i_enq_num) <= FETCH_W);
    assign enq_fire = i_enq_vld && o_enq_rdy && !i_flush && num_ok;
    assign deq_fire = o_deq_vld && i_deq_rdy && !i_flush;

    // Per-lane predecode; lane k sits at pc + 4k.
    always_comb begin
        for (int k = 0; k < FETCH_W; k++) begin
            lane[k] = predecode(i_enq_inst[32*k +: 32], i_enq_pc + XLEN'(4 * k),
                                i_enq_bflag[k]);
        end
    end

    // Storage array is intentionally not reset; validity comes from the pointers.
    always_ff @(posedge i_clk) begin
        if (enq_fire) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (NW'(k) < i_enq_num)
                    mem[wr_ptr[AW-1:0] + AW'(k)] <= lane[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire)
                wr_ptr <= wr_ptr + PW'(i_enq_num);
            if (deq_fire)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign head         = mem[rd_ptr[AW-1:0]];
    assign o_deq_inst   = head.inst;
    assign o_deq_pc     = head.pc;
    assign o_deq_bflag  = head.bflag;
    assign o_deq_jal    = head.jal;
    assign o_deq_jalr   = head.jalr;
    assign o_deq_bxx    = head.bxx;
    assign o_deq_rs1idx = head.rs1idx;
    assign o_deq_bp_imm = head.imm;

    enq_num_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_enq_vld && !i_flush) |-> num_ok);

endmodule
